// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage MIPS pipeline registers.
// Holds the default datapath width, the bubble instruction and the IF/ID bundle type.
package pipeline_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // sll $0,$0,0 encodes as all zeros; used for reset and flush bubbles.
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] pcPlus4;
    logic [DEFAULT_WIDTH-1:0] instr;
    logic                     valid;
  } if_id_t;

  function automatic if_id_t bubble();
    if_id_t b;
    b.pcPlus4 = '0;
    b.instr   = DEFAULT_NOP_INSTR;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, flush value and load enable.
// Priority: reset, then flush, then enable; otherwise hold.
module pipe_reg #(
  parameter int unsigned         Width    = 32,
  parameter logic [Width-1:0]    ResetVal = '0,
  parameter logic [Width-1:0]    FlushVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= ResetVal;
    end else if (flush) begin
      q <= FlushVal;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register: registers PC+4 and the fetched instruction for decode,
// with stall (enable low), bubble insertion (flush) and a valid flag for hazard logic.
module if_id_register
  import pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc_plus4_in,
  output logic [WIDTH-1:0] pc_plus4_out,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out
);

  pipe_reg #(
    .Width    (WIDTH),
    .ResetVal ('0),
    .FlushVal ('0)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .flush  (flush),
    .d      (pc_plus4_in),
    .q      (pc_plus4_out)
  );

  pipe_reg #(
    .Width    (WIDTH),
    .ResetVal (NOP_INSTR),
    .FlushVal (NOP_INSTR)
  ) u_instr_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .flush  (flush),
    .d      (instr_in),
    .q      (instr_out)
  );

  // Any load that is neither reset nor flush carries a real fetched instruction.
  pipe_reg #(
    .Width    (1),
    .ResetVal (1'b0),
    .FlushVal (1'b0)
  ) u_valid_reg (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .flush  (flush),
    .d      (1'b1),
    .q      (valid_out)
  );

endmodule

// File: tb/tb_if_id_register.sv
// Scoreboard bench for if_id_register: directed plan followed by random traffic,
// expected register contents queued by the driver and checked by an independent monitor.
module tb_if_id_register;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pcIn = '0;
  logic [31:0] instrIn = '0;
  logic [31:0] pcOut;
  logic [31:0] instrOut;
  logic        validOut;

  if_id_t expQ[$];
  if_id_t model;
  int     total = 0;
  int     bad = 0;
  bit     stimDone = 1'b0;

  always #5 clk = ~clk;

  if_id_register #(
    .WIDTH     (32),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .pc_plus4_in  (pcIn),
    .pc_plus4_out (pcOut),
    .instr_in     (instrIn),
    .instr_out    (instrOut),
    .valid_out    (validOut)
  );

  // Drive one cycle of inputs and queue what the decode stage should see after the edge.
  task automatic step(input logic r, input logic f, input logic e,
                      input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    reset   = r;
    flush   = f;
    enable  = e;
    pcIn    = pc;
    instrIn = ins;
    if (r || f) begin
      model.pcPlus4 = 32'd0;
      model.instr   = 32'h0000_0000;
      model.valid   = 1'b0;
    end else if (e) begin
      model.pcPlus4 = pc;
      model.instr   = ins;
      model.valid   = 1'b1;
    end
    expQ.push_back(model);
  endtask

  initial begin
    model = '0;
    // Reset for two edges.
    step(1, 0, 1, 32'd9, 32'h2002_0005);
    step(1, 0, 1, 32'd9, 32'h2002_0005);
    // Streaming on both paths.
    step(0, 0, 1, 32'd9, 32'd0);
    step(0, 0, 1, 32'd2, 32'd2);
    step(0, 0, 1, 32'd4, 32'd4);
    step(0, 0, 1, 32'd6, 32'd6);
    // Stall holds the last load while inputs move.
    step(0, 0, 1, 32'd4, 32'h8C08_0000);
    step(0, 0, 0, 32'd6, 32'hAC09_0004);
    step(0, 0, 0, 32'd6, 32'hAC09_0004);
    step(0, 0, 0, 32'd6, 32'hAC09_0004);
    step(0, 0, 1, 32'd6, 32'hAC09_0004);
    // Flush wins over a stall.
    step(0, 1, 0, 32'd8, 32'h1000_0003);
    step(0, 0, 0, 32'd8, 32'h1000_0003);
    // Reset mid-stream, then reload.
    step(0, 0, 1, 32'd12, 32'h2108_0001);
    step(1, 0, 1, 32'd2, 32'h2108_0002);
    step(0, 0, 1, 32'd2, 32'h2108_0002);
    // Flush together with enable, and reset together with flush.
    step(0, 1, 1, 32'd16, 32'h0123_4567);
    step(1, 1, 1, 32'd20, 32'h89AB_CDEF);
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 70), $urandom, $urandom);
    end
    stimDone = 1'b1;
  end

  initial begin
    if_id_t exp;
    int cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      cycles++;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        total++;
        if (pcOut !== exp.pcPlus4 || instrOut !== exp.instr || validOut !== exp.valid) begin
          bad++;
          $display("FAIL check%0d: got pc=%h instr=%h valid=%b, want pc=%h instr=%h valid=%b",
                   total, pcOut, instrOut, validOut, exp.pcPlus4, exp.instr, exp.valid);
        end
      end
      if (stimDone && expQ.size() == 0) break;
      if (cycles > 5000) begin
        bad++;
        $display("FAIL timeout: got %0d cycles, want stimulus done within 5000", cycles);
        break;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
